muxn_pipe: RTL and testbench
============================

MUXN_PIPE -- requirements
Module: muxn_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data width of each input and of the output.
REQ-002 Parameter N, default 5: number of data inputs, legal range 2..16.
REQ-003 Derived constant SELW = clog2(N): width of the select field.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 d  in  N*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-007 s  in  SELW  encoded select, sampled with the input beat.
REQ-008 in_valid  in  1  producer presents a beat (d, s).
REQ-009 in_ready  out  1  block can accept a beat; driven from a register.
REQ-010 out_valid  out  1  y holds a valid selected word.
REQ-011 out_ready  in  1  consumer takes y this cycle.
REQ-012 y  out  WIDTH  selected word, driven from a register.
REQ-013 flush  in  1  synchronous discard of all buffered beats.
REQ-014 sel_err  out  1  sticky flag: an out-of-range select was accepted.

Function
REQ-015 A beat is accepted when in_valid && in_ready; a beat is popped when out_valid && out_ready.
REQ-016 Selection: s < N selects input s. s >= N selects input N-1 (saturating) and sets sel_err.
REQ-017 Latency: a beat accepted in cycle t appears on y with out_valid=1 in cycle t+1 if the buffer was empty.
REQ-018 Buffering: a main register drives y; a skid register holds one extra beat. This gives full throughput of one beat per cycle with a registered in_ready.
REQ-019 The occupancy FSM has three states: EMPTY, ONE and TWO. out_valid = (state != EMPTY). in_ready = (state != TWO).
REQ-020 EMPTY: accept -> ONE, with the main register loaded.
REQ-021 ONE, with accept only -> TWO, with the skid register loaded.
REQ-022 ONE, with pop only -> EMPTY.
REQ-023 ONE, with accept and pop in the same cycle -> ONE, with the main register loaded with the new beat.
REQ-024 TWO, with pop -> ONE, with the main register loaded from the skid register. No accept is possible in TWO.
REQ-025 Beat order is strictly preserved; no beat is duplicated or dropped except by flush or reset.
REQ-026 y and the skid contents hold their value while not popped, regardless of d and s.
REQ-027 Flush has priority over accept and pop: the next state is EMPTY and any beat offered in the flush cycle is discarded. sel_err is not cleared by flush.
REQ-028 sel_err is set in the cycle after an accepted out-of-range beat. It stays set until reset, and is not raised by unaccepted beats.
REQ-029 When N is a power of two, sel_err is constant 0.

Reset
REQ-030 While reset_n = 0 at a clock edge, the following values are applied: state = EMPTY, out_valid = 0, in_ready = 1, sel_err = 0, y = 0, skid register = 0.
REQ-031 Asserting reset mid-stream discards all buffered beats.
REQ-032 Reset has priority over flush, accept and pop.

Structure
REQ-033 The following belong in a shared package: the FSM state encoding (EMPTY=2'b00, ONE=2'b01, TWO=2'b10) and a function computing SELW from N.
REQ-034 The combinational saturating selector is a separate sub-module, muxn_sel. It has parameters WIDTH and N, inputs d and s, and outputs y and oob.
REQ-035 muxn_pipe instantiates muxn_sel once and contains the FSM, the main and skid registers, and the sel_err register.

Verification
REQ-036 Directed scenarios:
- N=5, out_ready=1, beats s=0..4 with d[k]=k+1 -> y = 1,2,3,4,5 in consecutive cycles, each one cycle after its accept; sel_err=0.
- N=5, accept one beat with s=6 and d4=0xDEAD -> y=0xDEAD; sel_err=1 and remains 1 after a later flush.
- out_ready=0, three beats offered (A, B, C) -> A and B accepted, in_ready=0, C held by the producer. Release out_ready -> output order A, B, C with no loss.
- In TWO state, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the offered beat never appears on y.
- Streaming at full rate, pull reset_n low for one cycle -> all outputs take their REQ-030 values; the first post-reset beat appears 1 cycle after acceptance.
- N=8, any s value -> sel_err stays 0 throughout.

Source files
------------

// File: rtl/muxn_pipe_pkg.sv
// Shared definitions for the muxn_pipe slice: occupancy state encoding and
// select-width helper.
package muxn_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } occ_state_e;

  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 16;

  // Width of an encoded select able to address n inputs; never below 1 bit.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/muxn_sel.sv
// Combinational N:1 selector; out-of-range selects saturate to the last input
// and raise oob.
module muxn_sel
  import muxn_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 5,
  localparam int SELW = sel_width(N)
) (
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]    s,
  output logic [WIDTH-1:0]   y,
  output logic               oob
);

  logic [SELW-1:0] sel_idx;

  // With a power-of-two N every encodable select is in range.
  generate
    if (N == (1 << SELW)) begin : g_full
      assign oob = 1'b0;
    end else begin : g_partial
      assign oob = ({1'b0, s} >= (SELW+1)'(N));
    end
  endgenerate

  assign sel_idx = oob ? SELW'(N - 1) : s;

  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_idx == SELW'(k)) begin
        y = d[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// Registered N:1 mux with a two-entry (main + skid) valid/ready pipeline,
// synchronous flush and a sticky out-of-range select flag.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing buffered, y not valid
// ST_ONE   | main register holds the head beat
// ST_TWO   | main holds the head beat, skid holds the next
module muxn_pipe
  import muxn_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 5,
  localparam int SELW = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]    s,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  input  logic               flush,
  output logic               sel_err
);

  occ_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic [WIDTH-1:0] sel_word;
  logic             sel_oob;
  logic             in_ready_q, out_valid_q, sel_err_q;
  logic             accept, pop;
  logic             load_main_in, load_main_skid, load_skid;

  muxn_sel #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_sel (
    .d   (d),
    .s   (s),
    .y   (sel_word),
    .oob (sel_oob)
  );

  assign accept = in_valid && in_ready_q;
  assign pop    = out_valid_q && out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs are registered copies decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
      if (load_main_in) begin
        main_q <= sel_word;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= sel_word;
      end
      if (accept && sel_oob && !flush) begin
        sel_err_q <= 1'b1;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = main_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_muxn_pipe.sv
// Scoreboard bench for muxn_pipe: an N=5 instance with a queue model of the
// two-entry buffer, and an N=8 instance for the power-of-two select case.
module tb_muxn_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;

  logic [5*W-1:0] d5 = '0;
  logic [2:0]     s5 = '0;
  logic           in_valid5 = 1'b0, out_ready5 = 1'b0, flush5 = 1'b0;
  logic           in_ready5, out_valid5, sel_err5;
  logic [W-1:0]   y5;

  logic [8*W-1:0] d8 = '0;
  logic [2:0]     s8 = '0;
  logic           in_valid8 = 1'b0, out_ready8 = 1'b1, flush8 = 1'b0;
  logic           in_ready8, out_valid8, sel_err8;
  logic [W-1:0]   y8;

  int n_vec = 0;
  int n_err = 0;
  bit armed = 1'b0;
  bit exp_err = 1'b0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  muxn_pipe #(.WIDTH(W), .N(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .d(d5), .s(s5), .in_valid(in_valid5),
    .in_ready(in_ready5), .out_valid(out_valid5), .out_ready(out_ready5),
    .y(y5), .flush(flush5), .sel_err(sel_err5)
  );

  muxn_pipe #(.WIDTH(W), .N(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .d(d8), .s(s8), .in_valid(in_valid8),
    .in_ready(in_ready8), .out_valid(out_valid8), .out_ready(out_ready8),
    .y(y8), .flush(flush8), .sel_err(sel_err8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5*W-1:0] pack5(input logic [W-1:0] base);
    logic [5*W-1:0] v;
    for (int k = 0; k < 5; k++) v[k*W +: W] = base + W'(k);
    return v;
  endfunction

  function automatic logic [W-1:0] pick5(input logic [5*W-1:0] dv, input logic [2:0] sv);
    int k;
    k = (sv < 3'd5) ? int'(sv) : 4;
    return dv[k*W +: W];
  endfunction

  // Model checks outputs of the current cycle, then applies the handshake
  // that the next rising edge will see.
  always @(negedge clk) begin
    if (armed) begin
      bit m_acc, m_pop;
      check_eq("out_valid", {31'b0, out_valid5}, {31'b0, exp_q.size() != 0});
      check_eq("in_ready", {31'b0, in_ready5}, {31'b0, exp_q.size() < 2});
      check_eq("sel_err", {31'b0, sel_err5}, {31'b0, exp_err});
      if (exp_q.size() != 0) check_eq("y", {16'b0, y5}, {16'b0, exp_q[0]});
      m_acc = in_valid5 && (exp_q.size() < 2);
      m_pop = out_ready5 && (exp_q.size() != 0);
      if (!reset_n) begin
        exp_q.delete();
        exp_err = 1'b0;
      end else if (flush5) begin
        exp_q.delete();
      end else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_acc) begin
          exp_q.push_back(pick5(d5, s5));
          if (s5 >= 3'd5) exp_err = 1'b1;
        end
      end
    end
  end

  task automatic send5(input logic [2:0] sv, input logic [W-1:0] base);
    bit ok;
    d5 = pack5(base);
    s5 = sv;
    in_valid5 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid5 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'b0, out_valid5}, 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready5}, 32'd1);
    check_eq("rst_y", {16'b0, y5}, 32'd0);
    check_eq("rst_sel_err", {31'b0, sel_err5}, 32'd0);
    armed = 1'b1;
    reset_n = 1'b1;
    idle(1);

    // Streaming s=0..4 with d[k]=k+1.
    out_ready5 = 1'b1;
    for (int k = 0; k < 5; k++) send5(3'(k), 16'd1);
    idle(3);

    // Out-of-range select saturates to input 4; flag survives flush.
    send5(3'd6, 16'hDEA9);
    idle(2);
    check_eq("oob_sel_err", {31'b0, sel_err5}, 32'd1);
    flush5 = 1'b1;
    idle(1);
    flush5 = 1'b0;
    check_eq("sel_err_after_flush", {31'b0, sel_err5}, 32'd1);

    // Back-pressure: A, B buffered, C held until the consumer drains.
    out_ready5 = 1'b0;
    send5(3'd0, 16'h100);
    send5(3'd1, 16'h200);
    d5 = pack5(16'h300);
    s5 = 3'd2;
    in_valid5 = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("c_held_in_ready", {31'b0, in_ready5}, 32'd0);
    out_ready5 = 1'b1;
    send5(3'd2, 16'h300);
    idle(4);

    // Flush while full with a beat offered: the beat must never appear.
    out_ready5 = 1'b0;
    send5(3'd0, 16'h10);
    send5(3'd3, 16'h20);
    d5 = pack5(16'h7770);
    s5 = 3'd1;
    in_valid5 = 1'b1;
    flush5 = 1'b1;
    idle(1);
    flush5 = 1'b0;
    in_valid5 = 1'b0;
    check_eq("flush_out_valid", {31'b0, out_valid5}, 32'd0);
    check_eq("flush_in_ready", {31'b0, in_ready5}, 32'd1);
    out_ready5 = 1'b1;
    send5(3'd2, 16'h40);
    idle(3);

    // Reset mid-stream at full rate.
    send5(3'd0, 16'h1000);
    send5(3'd1, 16'h2000);
    d5 = pack5(16'h3000);
    s5 = 3'd3;
    in_valid5 = 1'b1;
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    in_valid5 = 1'b0;
    check_eq("midrst_out_valid", {31'b0, out_valid5}, 32'd0);
    check_eq("midrst_in_ready", {31'b0, in_ready5}, 32'd1);
    check_eq("midrst_y", {16'b0, y5}, 32'd0);
    check_eq("midrst_sel_err", {31'b0, sel_err5}, 32'd0);
    send5(3'd4, 16'h50);
    check_eq("post_rst_latency", {31'b0, out_valid5}, 32'd1);
    idle(3);

    // N=8: every select is legal, flag never rises.
    in_valid8 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int sv;
      sv = (i < 8) ? i : int'($urandom_range(0, 7));
      for (int j = 0; j < 8; j++) d8[j*W +: W] = W'(16'h800 + i*16 + j);
      s8 = 3'(sv);
      idle(1);
      check_eq("n8_y", {16'b0, y8}, 32'(16'h800 + i*16 + sv));
      check_eq("n8_sel_err", {31'b0, sel_err8}, 32'd0);
    end
    in_valid8 = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
